// File: rtl/cpu_mem_pkg.sv
// Shared memory-command encodings and the access-unit state type for the multicycle CPU.
package cpu_mem_pkg;

   typedef logic [1:0] mem_cmd_t;

   localparam mem_cmd_t MNONE  = 2'b00;
   localparam mem_cmd_t MREAD  = 2'b01;
   localparam mem_cmd_t MWRITE = 2'b10;

   typedef enum logic [2:0] {
      MAU_IDLE,
      MAU_FETCH,
      MAU_LOAD,
      MAU_STORE,
      MAU_ERR
   } mau_state_e;

endpackage

// File: rtl/mem_access_unit_wait_timer.sv
// Cycle counter for memory-access timeouts: synchronous clear, count enable, limit-hit flag.
module wait_timer #(
   parameter int unsigned LIMIT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic hit
);

   localparam int unsigned CNT_W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

   logic [CNT_W-1:0] cnt;

   // A limit of 0 means the timeout is disabled, so hit never rises.
   assign hit = (LIMIT != 0) && (cnt == CNT_W'(LIMIT));

   // NOTE: sequential state is updated with non-blocking assignments only, so every
   // flop samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !hit) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access front end: owns PC/IR/data-address/read-data registers and sequences
// fetch, load and store requests to a variable-latency memory with an optional timeout.
module mem_access_unit
   import cpu_mem_pkg::*;
#(
   parameter int unsigned       DATA_W   = 16,
   parameter int unsigned       ADDR_W   = 9,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned       MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic              ls_req,
   input  logic              ls_write,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_target,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] ir,
   output logic [DATA_W-1:0] ls_rdata,
   output logic [1:0]        mem_cmd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   mau_state_e        state, state_nxt;
   logic [ADDR_W-1:0] pc_q, addr_q;
   logic [DATA_W-1:0] ir_q, rdata_q, wdata_q;
   logic              done_q;
   logic              in_access, timeout;

   assign in_access = (state == MAU_FETCH) || (state == MAU_LOAD) || (state == MAU_STORE);

   // Counter is held clear in IDLE, so it starts from zero on entry to every access.
   wait_timer #(.LIMIT(MAX_WAIT)) u_wait_timer (
      .clk   (clk),
      .reset (reset),
      .clr   (!in_access),
      .en    (in_access && !mem_ready),
      .hit   (timeout)
   );

   // NOTE: every combinational output gets a default before the case statement so no
   // path through the block leaves a signal unassigned and infers a latch.
   always_comb begin
      state_nxt = state;
      mem_cmd   = MNONE;
      mem_addr  = pc_q;
      unique case (state)
         MAU_IDLE: begin
            if (ls_req) begin
               state_nxt = ls_write ? MAU_STORE : MAU_LOAD;
            end else if (fetch_req) begin
               state_nxt = MAU_FETCH;
            end
         end
         MAU_FETCH, MAU_LOAD, MAU_STORE: begin
            mem_cmd = (state == MAU_STORE) ? MWRITE : MREAD;
            if (state != MAU_FETCH) mem_addr = addr_q;
            // mem_ready in the limit cycle still completes normally.
            if (mem_ready)    state_nxt = MAU_IDLE;
            else if (timeout) state_nxt = MAU_ERR;
         end
         MAU_ERR: begin
            mem_addr = addr_q;
         end
         default: begin
            state_nxt = MAU_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= MAU_IDLE;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         rdata_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= in_access && mem_ready;
         if (state == MAU_IDLE) begin
            if (pc_load) pc_q <= pc_target;
            if (ls_req) begin
               addr_q  <= ls_addr;
               wdata_q <= ls_wdata;
            end
         end
         if (state == MAU_FETCH && mem_ready) begin
            ir_q <= mem_rdata;
            pc_q <= pc_q + ADDR_W'(1);
         end
         if (state == MAU_LOAD && mem_ready) begin
            rdata_q <= mem_rdata;
         end
      end
   end

   assign busy      = (state != MAU_IDLE);
   assign err       = (state == MAU_ERR);
   assign done      = done_q;
   assign pc        = pc_q;
   assign ir        = ir_q;
   assign ls_rdata  = rdata_q;
   assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized accesses
// against a transaction-level model with its own memory image.
module tb_mem_access_unit;
   import cpu_mem_pkg::*;

   localparam int DW = 16;
   localparam int AW = 9;
   localparam int MW = 15;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          fetch_req = 1'b0, ls_req = 1'b0, ls_write = 1'b0, pc_load = 1'b0;
   logic [AW-1:0] ls_addr = '0, pc_target = '0;
   logic [DW-1:0] ls_wdata = '0, mem_rdata = '0;
   logic          mem_ready = 1'b0;
   logic          busy, done, err;
   logic [AW-1:0] pc, mem_addr;
   logic [DW-1:0] ir, ls_rdata, mem_wdata;
   logic [1:0]    mem_cmd;

   mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC('0), .MAX_WAIT(MW)) dut (
      .clk(clk), .reset(reset), .fetch_req(fetch_req), .ls_req(ls_req), .ls_write(ls_write),
      .ls_addr(ls_addr), .ls_wdata(ls_wdata), .pc_load(pc_load), .pc_target(pc_target),
      .busy(busy), .done(done), .err(err), .pc(pc), .ir(ir), .ls_rdata(ls_rdata),
      .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   // Reference model: architectural registers plus the memory contents seen by the CPU.
   logic [AW-1:0] m_pc, m_laddr;
   logic [DW-1:0] m_ir, m_rdata, m_lwdata;
   logic [DW-1:0] mem_img [0:(1<<AW)-1];
   int            n_vec = 0;
   int            n_err = 0;

   task automatic model_reset();
      m_pc = '0; m_ir = '0; m_rdata = '0; m_laddr = '0; m_lwdata = '0;
   endtask

   // Called at a negedge while idle; returns at a negedge one cycle after done.
   task automatic do_access(input bit is_ls, input bit wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input bit pcl,
                            input logic [AW-1:0] tgt, input int waits, input string tag);
      logic [AW-1:0] exp_addr;
      logic [1:0]    ecmd;
      fetch_req = !is_ls; ls_req = is_ls; ls_write = wr; ls_addr = a; ls_wdata = wd;
      pc_load = pcl; pc_target = tgt;
      @(posedge clk);
      if (pcl) m_pc = tgt;
      if (is_ls) begin m_laddr = a; m_lwdata = wd; end
      exp_addr = is_ls ? a : m_pc;
      ecmd = (is_ls && wr) ? MWRITE : MREAD;
      @(negedge clk);
      fetch_req = 1'b0; ls_req = 1'b0; pc_load = 1'b0;
      ls_addr = AW'($urandom); ls_wdata = DW'($urandom); pc_target = AW'($urandom);
      ls_write = 1'($urandom);
      for (int c = 0; c <= waits; c++) begin
         n_vec++;
         if ({mem_cmd, mem_addr, mem_wdata, busy, done} !== {ecmd, exp_addr, m_lwdata, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL %s access cyc=%0d got cmd=%b addr=%h wdata=%h busy=%b done=%b, want cmd=%b addr=%h wdata=%h busy=1 done=0",
                     tag, c, mem_cmd, mem_addr, mem_wdata, busy, done, ecmd, exp_addr, m_lwdata);
         end
         mem_ready = (c == waits);
         mem_rdata = (c == waits) ? mem_img[exp_addr] : DW'($urandom);
         @(negedge clk);
      end
      mem_ready = 1'b0; mem_rdata = DW'($urandom);
      if (!is_ls) begin
         m_ir = mem_img[exp_addr];
         m_pc = m_pc + 1'b1;
      end else if (wr) begin
         mem_img[a] = wd;
      end else begin
         m_rdata = mem_img[a];
      end
      n_vec++;
      if ({done, busy, err, mem_cmd, pc, ir, ls_rdata, mem_addr} !==
          {1'b1, 1'b0, 1'b0, MNONE, m_pc, m_ir, m_rdata, m_pc}) begin
         n_err++;
         $display("FAIL %s complete got done=%b busy=%b err=%b cmd=%b pc=%h ir=%h rdata=%h addr=%h, want done=1 busy=0 err=0 cmd=00 pc=%h ir=%h rdata=%h addr=%h",
                  tag, done, busy, err, mem_cmd, pc, ir, ls_rdata, mem_addr, m_pc, m_ir, m_rdata, m_pc);
      end
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0) begin
         n_err++;
         $display("FAIL %s done_width got done=%b, want 0", tag, done);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_vec++;
      if ({busy, done, err, mem_cmd, mem_addr, mem_wdata, pc, ir, ls_rdata} !==
          {3'b000, MNONE, AW'(0), DW'(0), AW'(0), DW'(0), DW'(0)}) begin
         n_err++;
         $display("FAIL reset_state got busy=%b done=%b err=%b cmd=%b addr=%h wdata=%h pc=%h ir=%h rdata=%h, want all zero",
                  busy, done, err, mem_cmd, mem_addr, mem_wdata, pc, ir, ls_rdata);
      end
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_fetch();
      mem_img[0] = 16'hD105;
      do_access(1'b0, 1'b0, '0, '0, 1'b0, '0, 0, "fetch_min_latency");
      n_vec++;
      if ({ir, pc} !== {16'hD105, 9'h001}) begin
         n_err++;
         $display("FAIL fetch_result got ir=%h pc=%h, want ir=d105 pc=001", ir, pc);
      end
   endtask

   task automatic test_load();
      mem_img[9'h1F0] = 16'hBEEF;
      do_access(1'b1, 1'b0, 9'h1F0, DW'($urandom), 1'b0, '0, 3, "load_wait3");
      n_vec++;
      if ({ls_rdata, pc} !== {16'hBEEF, 9'h001}) begin
         n_err++;
         $display("FAIL load_result got rdata=%h pc=%h, want rdata=beef pc=001", ls_rdata, pc);
      end
   endtask

   task automatic test_store();
      do_access(1'b1, 1'b1, 9'h020, 16'h1234, 1'b0, '0, 4, "store_wait4");
      do_access(1'b1, 1'b0, 9'h020, DW'($urandom), 1'b0, '0, 1, "load_after_store");
      n_vec++;
      if (ls_rdata !== 16'h1234) begin
         n_err++;
         $display("FAIL store_readback got rdata=%h, want 1234", ls_rdata);
      end
   endtask

   task automatic test_priority();
      logic [AW-1:0] a;
      a = AW'($urandom);
      fetch_req = 1'b1; ls_req = 1'b1; ls_write = 1'b0; ls_addr = a;
      @(posedge clk);
      m_laddr = a; m_lwdata = ls_wdata;
      @(negedge clk);
      ls_req = 1'b0;
      for (int c = 0; c < 3; c++) begin
         n_vec++;
         if ({mem_cmd, mem_addr} !== {MREAD, a}) begin
            n_err++;
            $display("FAIL prio_load cyc=%0d got cmd=%b addr=%h, want cmd=01 addr=%h", c, mem_cmd, mem_addr, a);
         end
         mem_ready = (c == 2); mem_rdata = mem_img[a];
         @(negedge clk);
      end
      mem_ready = 1'b0;
      m_rdata = mem_img[a];
      n_vec++;
      if ({done, busy, ls_rdata} !== {1'b1, 1'b0, m_rdata}) begin
         n_err++;
         $display("FAIL prio_load_done got done=%b busy=%b rdata=%h, want done=1 busy=0 rdata=%h", done, busy, ls_rdata, m_rdata);
      end
      @(negedge clk);
      fetch_req = 1'b0;
      n_vec++;
      if ({mem_cmd, mem_addr, busy} !== {MREAD, m_pc, 1'b1}) begin
         n_err++;
         $display("FAIL prio_fetch_follows got cmd=%b addr=%h busy=%b, want cmd=01 addr=%h busy=1", mem_cmd, mem_addr, busy, m_pc);
      end
      mem_ready = 1'b1; mem_rdata = mem_img[m_pc];
      @(negedge clk);
      mem_ready = 1'b0;
      m_ir = mem_img[m_pc]; m_pc = m_pc + 1'b1;
      n_vec++;
      if ({done, ir, pc} !== {1'b1, m_ir, m_pc}) begin
         n_err++;
         $display("FAIL prio_fetch_done got done=%b ir=%h pc=%h, want done=1 ir=%h pc=%h", done, ir, pc, m_ir, m_pc);
      end
      @(negedge clk);
   endtask

   task automatic test_pc_wrap();
      do_access(1'b0, 1'b0, '0, '0, 1'b1, 9'h1FF, 1, "fetch_pc_load_wrap");
      n_vec++;
      if (pc !== 9'h000) begin
         n_err++;
         $display("FAIL pc_wrap got pc=%h, want 000", pc);
      end
   endtask

   task automatic test_timeout_boundary();
      do_access(1'b1, 1'b0, AW'($urandom), DW'($urandom), 1'b0, '0, MW, "load_ready_at_limit");
      do_access(1'b0, 1'b0, '0, '0, 1'b0, '0, MW, "fetch_ready_at_limit");
   endtask

   task automatic test_timeout();
      fetch_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      fetch_req = 1'b0;
      for (int c = 0; c <= MW; c++) begin
         n_vec++;
         if ({mem_cmd, mem_addr, err} !== {MREAD, m_pc, 1'b0}) begin
            n_err++;
            $display("FAIL timeout_wait cyc=%0d got cmd=%b addr=%h err=%b, want cmd=01 addr=%h err=0", c, mem_cmd, mem_addr, err, m_pc);
         end
         @(negedge clk);
      end
      for (int c = 0; c < 3; c++) begin
         n_vec++;
         if ({mem_cmd, mem_addr, err, busy, done, pc} !== {MNONE, m_laddr, 1'b1, 1'b1, 1'b0, m_pc}) begin
            n_err++;
            $display("FAIL timeout_err cyc=%0d got cmd=%b addr=%h err=%b busy=%b done=%b pc=%h, want cmd=00 addr=%h err=1 busy=1 done=0 pc=%h",
                     c, mem_cmd, mem_addr, err, busy, done, pc, m_laddr, m_pc);
         end
         mem_ready = 1'b1; fetch_req = 1'b1; ls_req = 1'b1;
         @(negedge clk);
      end
      #2 reset = 1'b0;
      mem_ready = 1'b0; fetch_req = 1'b0; ls_req = 1'b0;
      #1;
      model_reset();
      n_vec++;
      if ({err, busy, done, mem_cmd, mem_addr, pc} !== {3'b000, MNONE, AW'(0), AW'(0)}) begin
         n_err++;
         $display("FAIL timeout_reset got err=%b busy=%b done=%b cmd=%b addr=%h pc=%h, want all zero", err, busy, done, mem_cmd, mem_addr, pc);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset_mid_store();
      fetch_req = 1'b0; ls_req = 1'b1; ls_write = 1'b1;
      ls_addr = AW'($urandom); ls_wdata = DW'($urandom);
      @(posedge clk);
      @(negedge clk);
      ls_req = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      model_reset();
      n_vec++;
      if ({mem_cmd, busy, done, mem_addr, mem_wdata, pc, ir, ls_rdata} !==
          {MNONE, 2'b00, AW'(0), DW'(0), AW'(0), DW'(0), DW'(0)}) begin
         n_err++;
         $display("FAIL reset_mid_store got cmd=%b busy=%b done=%b addr=%h wdata=%h pc=%h ir=%h rdata=%h, want all zero",
                  mem_cmd, busy, done, mem_addr, mem_wdata, pc, ir, ls_rdata);
      end
      mem_ready = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         mem_ready = 1'b0;
         n_vec++;
         if ({done, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_no_done cyc=%0d got done=%b busy=%b, want 0 0", c, done, busy);
         end
      end
   endtask

   task automatic test_random();
      int kind;
      for (int i = 0; i < 40; i++) begin
         kind = int'($urandom_range(0, 2));
         do_access(kind != 0, kind == 2, AW'($urandom), DW'($urandom),
                   $urandom_range(0, 3) == 0, AW'($urandom), int'($urandom_range(0, 5)), "random");
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem_img[i] = DW'($urandom);
      @(negedge clk);
      test_reset();
      test_fetch();
      test_load();
      test_store();
      test_priority();
      test_pc_wrap();
      test_timeout_boundary();
      test_timeout();
      test_random();
      test_reset_mid_store();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised memory-access front end for the multicycle CPU.
- Owns the program counter, instruction register, data-address register and read-data register.
- Sequences instruction fetches and load/store accesses to a variable-latency memory using a request/ready handshake, with an optional timeout.
- Sits between the control FSM and datapath on one side and the memory block on the other.
- Supersedes the fixed-width, single-cycle PC/IR/address-mux arrangement.

Parameters:
- DATA_W, 16: instruction/data word width.
- ADDR_W, 9: memory address width; PC and data-address register width.
- RESET_PC, 0: PC value after reset, ADDR_W bits.
- MAX_WAIT, 15: cycles allowed in an access state without mem_ready before error. 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_req  in  1  control requests an instruction fetch.
- ls_req  in  1  control requests a load/store.
- ls_write  in  1  with ls_req: 1 = store, 0 = load.
- ls_addr  in  ADDR_W  effective address from datapath_out[ADDR_W-1:0].
- ls_wdata  in  DATA_W  store data from the datapath.
- pc_load  in  1  load PC from pc_target.
- pc_target  in  ADDR_W  branch/jump target.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when an access completes.
- err  out  1  sticky timeout flag.
- pc  out  ADDR_W  current PC.
- ir  out  DATA_W  instruction register.
- ls_rdata  out  DATA_W  last loaded word (mdata to the datapath).
- mem_cmd  out  2  00 NONE, 01 MREAD, 10 MWRITE.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  store data to memory.
- mem_rdata  in  DATA_W  memory read data.
- mem_ready  in  1  memory completes the current access this cycle.

Behaviour:
- States: IDLE, FETCH, LOAD, STORE, ERR.
- Reset (reset=0, asynchronous, effective immediately, including mid-access):
  - state=IDLE, pc=RESET_PC, ir=0, ls_rdata=0, done=0, err=0.
  - Internal address/wdata latches = 0.
  - Outputs therefore: mem_cmd=NONE, mem_addr=RESET_PC, mem_wdata=0, busy=0.
  - Any in-flight access is abandoned; no register is updated from it.
- IDLE, request acceptance (requests are accepted only in IDLE):
  - ls_req has priority over fetch_req.
  - ls_req=1: latch ls_addr and ls_wdata, go to STORE if ls_write=1, else LOAD.
  - Else fetch_req=1: go to FETCH.
  - Requests in other states are ignored; control must wait for done.
- PC load in IDLE:
  - pc_load=1 loads pc_target at the edge.
  - pc_load together with fetch_req: the fetch uses pc_target, and on completion pc = pc_target+1.
  - pc_load outside IDLE is ignored.
- FETCH:
  - mem_cmd=MREAD, mem_addr=pc.
  - On a mem_ready cycle: ir<=mem_rdata, pc<=pc+1 modulo 2^ADDR_W (RESET_PC wraps naturally from 2^ADDR_W-1 to 0), next state IDLE.
- LOAD:
  - mem_cmd=MREAD, mem_addr=latched address.
  - On mem_ready: ls_rdata<=mem_rdata, next state IDLE.
- STORE:
  - mem_cmd=MWRITE, mem_addr=latched address, mem_wdata=latched data.
  - On mem_ready: next state IDLE.
  - mem_wdata holds the latched value in all states.
- Completion and latency:
  - done is registered: high for exactly the one cycle after the mem_ready edge, which is the first IDLE cycle, with ir/ls_rdata/pc already updated.
  - Minimum request-to-done latency = 2 cycles (request accepted at edge k, mem_ready high in cycle k+1, done high in cycle k+2).
- mem_addr is driven combinationally from state: pc in IDLE/FETCH, latched address in LOAD/STORE/ERR.
- Timeout:
  - Wait counter (width clog2(MAX_WAIT+1)) clears on entry to each access state and increments every cycle with mem_ready=0.
  - When the counter equals MAX_WAIT and mem_ready=0, next state is ERR.
  - mem_ready in the same cycle the limit is reached wins: normal completion.
- ERR: mem_cmd=NONE, err=1, busy=1, done never asserts; left only by reset.
- mem_ready while in IDLE or ERR is ignored.

Decomposition:
- Shared package cpu_mem_pkg:
  - mem_cmd constants MNONE=2'b00, MREAD=2'b01, MWRITE=2'b10.
  - State encoding for mem_access_unit.
- One sub-module, wait_timer: parametrised counter with clear, enable and limit-hit output.
- PC, IR and address registers use the existing load-enable register module.

Test Plan:
- Reset release, then fetch_req with memory mem_ready=1 immediately and mem_rdata=16'hD105 at address 0 -> MREAD at addr 0 for 1 cycle; done 2 cycles after request; ir=16'hD105; pc=1.
- Load with ls_addr=9'h1F0 and 3 wait cycles, memory returning 16'hBEEF -> MREAD to 0x1F0 for 4 cycles; ls_rdata=16'hBEEF; done once; pc unchanged.
- Store with ls_addr=9'h020, ls_wdata=16'h1234, inputs changed after acceptance -> MWRITE to 0x020 with data 0x1234 until mem_ready.
- Simultaneous fetch_req+ls_req (load) -> load first; fetch_req held until done -> fetch follows. Separately, pc_load=1 with pc_target=9'h1FF plus fetch_req -> fetch from 0x1FF; pc wraps to 0.
- mem_ready never asserted, MAX_WAIT=15 -> ERR after 15 wait cycles; err=1; mem_cmd=NONE; later mem_ready ignored. Reset clears err and restores pc=RESET_PC.
- reset asserted in the middle of a 5-cycle store -> mem_cmd=NONE immediately; ir, ls_rdata and pc take reset values; no done pulse.
